msp430_clock_switch_ctrl: RTL

MSP430_CLOCK_SWITCH_CTRL -- requirements
Module: msp430_clock_switch_ctrl

---
 rtl/msp430_clock_switch_pkg.sv | 15 +
 rtl/msp430_sync_cell.sv | 24 ++
 rtl/msp430_clock_switch_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/msp430_clock_switch_pkg.sv
// Shared state encoding and default sizing for the MSP430 clock switch controller.
package msp430_clock_switch_pkg;

  typedef enum logic [1:0] {
    StIdle0   = 2'd0,
    StSwTo1   = 2'd1,
    StActive1 = 2'd2,
    StSwTo0   = 2'd3
  } clk_sw_state_e;

  localparam int unsigned DefTimeoutW   = 8;
  localparam int unsigned DefLockEdges  = 3;
  localparam int unsigned DefBackCycles = 4;

endpackage

// File: rtl/msp430_sync_cell.sv
// Two-flop synchronizer bringing the clk_in1 toggle into the clk_in0_inv domain.
module msp430_sync_cell (
  input  logic clk_in0_inv,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in0_inv or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/msp430_clock_switch_ctrl.sv
// Clock source switch controller: selects clk_in1 once it shows activity, and falls
// back to clk_in0 on software request or when clk_in1 stops toggling.
module msp430_clock_switch_ctrl
  import msp430_clock_switch_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = DefTimeoutW,
  parameter int unsigned LOCK_EDGES  = DefLockEdges,
  parameter int unsigned BACK_CYCLES = DefBackCycles
) (
  input  logic clk_in0_inv,
  input  logic reset,
  input  logic scan_mode,
  input  logic sel_wr,
  input  logic sel_wdata,
  input  logic clk1_tgl,
  input  logic fail_clr,
  output logic selection,
  output logic sel_status,
  output logic busy,
  output logic fail_flag,
  output logic irq
);

  localparam int unsigned EdgeW = $clog2(LOCK_EDGES + 1);
  localparam int unsigned BackW = $clog2(BACK_CYCLES + 1);

  localparam logic [TIMEOUT_W-1:0] TimerMax  = '1;
  localparam logic [TIMEOUT_W-1:0] TimerLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [EdgeW-1:0]     EdgeLast  = EdgeW'(LOCK_EDGES - 1);
  localparam logic [EdgeW-1:0]     EdgeSat   = EdgeW'(LOCK_EDGES);
  localparam logic [BackW-1:0]     BackLast  = BackW'(BACK_CYCLES - 1);
  localparam logic [BackW-1:0]     BackSat   = BackW'(BACK_CYCLES);

  clk_sw_state_e        state_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic [EdgeW-1:0]     edge_cnt_q;
  logic [BackW-1:0]     back_cnt_q;
  logic                 sw_req_q;
  logic                 tgl_prev_q;
  logic                 tgl_sync;
  logic                 activity;

  msp430_sync_cell u_sync (
    .clk_in0_inv (clk_in0_inv),
    .reset       (reset),
    .din         (clk1_tgl),
    .dout        (tgl_sync)
  );

  assign activity = tgl_sync ^ tgl_prev_q;

  always_ff @(posedge clk_in0_inv or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle0;
      selection  <= 1'b0;
      sel_status <= 1'b0;
      busy       <= 1'b0;
      fail_flag  <= 1'b0;
      irq        <= 1'b0;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      back_cnt_q <= '0;
      sw_req_q   <= 1'b0;
      tgl_prev_q <= 1'b0;
    end else if (scan_mode) begin
      irq <= 1'b0;
    end else begin
      irq        <= 1'b0;
      tgl_prev_q <= tgl_sync;
      // A failure set later in this block overrides the clear.
      if (fail_clr) fail_flag <= 1'b0;

      unique case (state_q)
        StIdle0: begin
          if (sel_wr && sel_wdata && !fail_flag) begin
            state_q    <= StSwTo1;
            selection  <= 1'b1;
            busy       <= 1'b1;
            edge_cnt_q <= '0;
            timer_q    <= '0;
          end
        end

        StSwTo1: begin
          if (activity) begin
            if (edge_cnt_q != EdgeSat) edge_cnt_q <= edge_cnt_q + 1'b1;
            if (edge_cnt_q == EdgeLast) begin
              state_q    <= StActive1;
              sel_status <= 1'b1;
              busy       <= 1'b0;
              irq        <= 1'b1;
              timer_q    <= '0;
            end
          end else begin
            if (timer_q != TimerMax) timer_q <= timer_q + 1'b1;
            if (timer_q == TimerLast) begin
              state_q    <= StSwTo0;
              selection  <= 1'b0;
              sel_status <= 1'b0;
              fail_flag  <= 1'b1;
              irq        <= 1'b1;
              back_cnt_q <= '0;
              sw_req_q   <= 1'b0;
            end
          end
        end

        StActive1: begin
          if (activity) begin
            timer_q <= '0;
          end else if (timer_q != TimerMax) begin
            timer_q <= timer_q + 1'b1;
          end

          if (!activity && (timer_q == TimerLast)) begin
            state_q    <= StSwTo0;
            selection  <= 1'b0;
            sel_status <= 1'b0;
            busy       <= 1'b1;
            fail_flag  <= 1'b1;
            irq        <= 1'b1;
            back_cnt_q <= '0;
            sw_req_q   <= 1'b0;
          end else if (sel_wr && !sel_wdata) begin
            state_q    <= StSwTo0;
            selection  <= 1'b0;
            sel_status <= 1'b0;
            busy       <= 1'b1;
            back_cnt_q <= '0;
            sw_req_q   <= 1'b1;
          end
        end

        StSwTo0: begin
          if (back_cnt_q != BackSat) back_cnt_q <= back_cnt_q + 1'b1;
          if (back_cnt_q == BackLast) begin
            state_q <= StIdle0;
            busy    <= 1'b0;
            irq     <= sw_req_q;
          end
        end
      endcase
    end
  end

endmodule
